// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// 8N1 UART transmitter fed by a byte FIFO. Writes are queued while the FIFO
// has room; the transmit FSM pops one byte per frame and sends frames
// back-to-back with no idle gap while bytes are queued.
//
// Ports
//   i_Clock      : single clock, rising edge
//   i_Reset      : synchronous active-high reset
//   i_Tx_DV      : write strobe, pushes i_Tx_Byte when o_Tx_Ready is high
//   i_Tx_Byte    : byte to transmit
//   o_Tx_Ready   : FIFO not full
//   o_Tx_Serial  : UART line, idle high
//   o_Tx_Active  : high while a frame is on the line
//   o_Tx_Done    : one-cycle pulse after each completed frame
//   o_Fifo_Count : occupied FIFO entries, 0..FIFO_DEPTH
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Tx_DV,
    input  logic [7:0]                  i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CLK   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              bit_end;
    logic              stop_done_q;

    assign o_Tx_Ready = (o_Fifo_Count != FULL_COUNT);
    assign fifo_empty = (o_Fifo_Count == '0);
    assign bit_end    = (clk_cnt == LAST_CLK);

    // A write during reset is ignored; a write while full is dropped even
    // if the FSM pops on the same edge, because o_Tx_Ready reflects the
    // count before that edge.
    assign push = i_Tx_DV && o_Tx_Ready && !i_Reset;

    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_Fifo_Count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   o_Fifo_Count <= o_Fifo_Count + 1'b1;
                2'b01:   o_Fifo_Count <= o_Fifo_Count - 1'b1;
                default: o_Fifo_Count <= o_Fifo_Count;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The stop bit's last cycle chains straight into the next START when a
    // byte is waiting, which gives gap-free back-to-back frames.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
            end
            if (state == IDLE || bit_end) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
            end
        end
    end

    // Line outputs are registered from the current state, so the line trails
    // the state register by one cycle. The done pulse is delayed one more
    // stage so it lands on the cycle after the stop bit has fully left the
    // line.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
            stop_done_q <= 1'b0;
        end else begin
            case (state)
                START:   o_Tx_Serial <= 1'b0;
                DATA:    o_Tx_Serial <= shift_reg[bit_idx];
                default: o_Tx_Serial <= 1'b1;
            endcase
            o_Tx_Active <= (state != IDLE);
            stop_done_q <= (state == STOP) && bit_end;
            o_Tx_Done   <= stop_done_q;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A frame-level reference model (byte queue plus frame timeline) predicts
// every output cycle by cycle, and a line decoder rebuilds transmitted bytes
// from o_Tx_Serial for sequence checks.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Tx_DV = 1'b0;
    logic [7:0] i_Tx_Byte = 8'h00;
    logic       o_Tx_Ready;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;
    logic [4:0] o_Fifo_Count;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Tx_DV     (i_Tx_DV),
        .i_Tx_Byte   (i_Tx_Byte),
        .o_Tx_Ready  (o_Tx_Ready),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Done   (o_Tx_Done),
        .o_Fifo_Count(o_Fifo_Count)
    );

    always #5 i_Clock = ~i_Clock;

    // Reference model. A popped byte appears on the line for FRAME cycles
    // starting one edge after the pop; a frame occupies the transmitter for
    // FRAME edges, and the last of those edges may pop the next byte.
    logic [7:0] m_fifo[$];
    logic [7:0] m_done_log[$];
    logic [7:0] m_line_byte = 8'h00;
    logic [7:0] m_next_byte = 8'h00;
    int         m_busy = 0;
    int         m_line_pos = -1;
    bit         m_started = 1'b0;
    bit         m_done_next = 1'b0;
    bit         m_pop;
    bit         m_accept;
    int         m_bitn;
    int         rst_gen = 0;
    logic       exp_serial = 1'b1;
    logic       exp_active = 1'b0;
    logic       exp_done = 1'b0;
    logic [4:0] exp_count = 5'd0;
    logic       exp_ready = 1'b1;

    always @(posedge i_Clock) begin
        if (i_Reset) begin
            rst_gen++;
            m_fifo.delete();
            m_busy      = 0;
            m_line_pos  = -1;
            m_started   = 1'b0;
            m_done_next = 1'b0;
            exp_done    = 1'b0;
        end else begin
            exp_done    = m_done_next;
            m_done_next = 1'b0;
            if (m_line_pos >= 0) begin
                m_line_pos++;
                if (m_line_pos == FRAME) m_line_pos = -1;
            end
            if (m_started) begin
                m_line_pos  = 0;
                m_line_byte = m_next_byte;
                m_started   = 1'b0;
            end
            m_pop    = (m_busy <= 1) && (m_fifo.size() > 0);
            m_accept = i_Tx_DV && (m_fifo.size() < DEPTH);
            if (m_busy == 1) begin
                m_done_next = 1'b1;
                m_done_log.push_back(m_line_byte);
            end
            if (m_pop) begin
                m_next_byte = m_fifo.pop_front();
                m_started   = 1'b1;
                m_busy      = FRAME;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (m_accept) m_fifo.push_back(i_Tx_Byte);
        end
        exp_count  = 5'(m_fifo.size());
        exp_ready  = (m_fifo.size() != DEPTH);
        exp_active = (m_line_pos >= 0);
        if (m_line_pos < 0) begin
            exp_serial = 1'b1;
        end else begin
            m_bitn = m_line_pos / CPB;
            if (m_bitn == 0)      exp_serial = 1'b0;
            else if (m_bitn == 9) exp_serial = 1'b1;
            else                  exp_serial = m_line_byte[m_bitn-1];
        end
    end

    // Line decoder: detects a falling edge, samples mid-bit, aborts on reset.
    logic [7:0] dec_q[$];
    logic [7:0] dec_byte = 8'h00;
    int         dec_pos = 0;
    int         dec_rst_seen = 0;
    int         dec_frame_err = 0;
    int         dec_b;

    always @(negedge i_Clock) begin
        if (rst_gen != dec_rst_seen) begin
            dec_rst_seen = rst_gen;
            dec_pos      = 0;
        end else if (dec_pos == 0) begin
            if (o_Tx_Serial === 1'b0) begin
                dec_pos  = 1;
                dec_byte = 8'h00;
            end
        end else begin
            if (dec_pos % CPB == CPB / 2) begin
                dec_b = dec_pos / CPB;
                if (dec_b == 0 && o_Tx_Serial !== 1'b0) dec_frame_err++;
                if (dec_b >= 1 && dec_b <= 8) dec_byte[dec_b-1] = o_Tx_Serial;
                if (dec_b == 9 && o_Tx_Serial !== 1'b1) dec_frame_err++;
            end
            dec_pos++;
            if (dec_pos == FRAME) begin
                dec_q.push_back(dec_byte);
                dec_pos = 0;
            end
        end
    end

    task automatic test_reset();
        i_Reset   = 1'b1;
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'h77;
        repeat (3) @(negedge i_Clock);
        tests_run += 5;
        if (o_Tx_Serial !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_serial got %b expected 1", o_Tx_Serial); end
        if (o_Tx_Active !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_active got %b expected 0", o_Tx_Active); end
        if (o_Tx_Done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b expected 0", o_Tx_Done); end
        if (o_Fifo_Count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d expected 0", o_Fifo_Count); end
        if (o_Tx_Ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready got %b expected 1", o_Tx_Ready); end
        i_Reset = 1'b0;
        i_Tx_DV = 1'b0;
        repeat (3) @(negedge i_Clock);
        tests_run += 2;
        if (o_Fifo_Count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_write_ignored got %0d expected 0", o_Fifo_Count); end
        if (o_Tx_Serial !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_idle_line got %b expected 1", o_Tx_Serial); end
    endtask

    task automatic test_single_byte();
        logic [7:0] data = 8'hA5;
        logic       want_line;
        logic       want_act;
        int         b;
        @(negedge i_Clock);
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = data;
        for (int e = 0; e <= 45; e++) begin
            @(negedge i_Clock);
            i_Tx_DV = 1'b0;
            if (e >= 2 && e <= 41) begin
                b         = (e - 2) / CPB;
                want_act  = 1'b1;
                want_line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
            end else begin
                want_act  = 1'b0;
                want_line = 1'b1;
            end
            tests_run += 3;
            if (o_Tx_Serial !== want_line) begin tests_failed++; $display("[TB] FAIL single_serial edge %0d got %b expected %b", e, o_Tx_Serial, want_line); end
            if (o_Tx_Active !== want_act) begin tests_failed++; $display("[TB] FAIL single_active edge %0d got %b expected %b", e, o_Tx_Active, want_act); end
            if (o_Tx_Done !== (e == 42)) begin tests_failed++; $display("[TB] FAIL single_done edge %0d got %b expected %b", e, o_Tx_Done, (e == 42)); end
            if (e == 0 || e == 1) begin
                tests_run++;
                if (o_Fifo_Count !== ((e == 0) ? 5'd1 : 5'd0)) begin tests_failed++; $display("[TB] FAIL single_count edge %0d got %0d", e, o_Fifo_Count); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_edges[$];
        int base = dec_q.size();
        @(negedge i_Clock);
        for (int e = 0; e <= 130; e++) begin
            i_Tx_DV   = (e <= 2);
            i_Tx_Byte = 8'(e + 1);
            @(negedge i_Clock);
            if (o_Tx_Done === 1'b1) done_edges.push_back(e);
            if (e == 2) begin
                tests_run++;
                if (o_Fifo_Count !== 5'd2) begin tests_failed++; $display("[TB] FAIL b2b_count_e2 got %0d expected 2", o_Fifo_Count); end
            end
            if (e == 42 || e == 82) begin
                tests_run++;
                if (o_Tx_Serial !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_no_gap edge %0d got %b expected 0", e, o_Tx_Serial); end
            end
        end
        i_Tx_DV = 1'b0;
        tests_run += 2;
        if (o_Fifo_Count !== 5'd0) begin tests_failed++; $display("[TB] FAIL b2b_count_end got %0d expected 0", o_Fifo_Count); end
        if (done_edges.size() != 3) begin
            tests_failed++; $display("[TB] FAIL b2b_done_pulses got %0d expected 3", done_edges.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (done_edges[i] != 42 + FRAME * i) begin tests_failed++; $display("[TB] FAIL b2b_done_edge %0d got %0d expected %0d", i, done_edges[i], 42 + FRAME * i); end
            end
        end
        tests_run++;
        if (dec_q.size() != base + 3) begin
            tests_failed++; $display("[TB] FAIL b2b_frames got %0d expected 3", dec_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (dec_q[base+i] !== 8'(i + 1)) begin tests_failed++; $display("[TB] FAIL b2b_byte %0d got %h expected %h", i, dec_q[base+i], 8'(i + 1)); end
            end
        end
    endtask

    task automatic test_overflow();
        int   base = dec_q.size();
        int   guard = 0;
        logic [4:0] want;
        @(negedge i_Clock);
        for (int e = 0; e <= 17; e++) begin
            i_Tx_DV   = 1'b1;
            i_Tx_Byte = 8'(e);
            @(negedge i_Clock);
            want = (e == 0) ? 5'd1 : (e > 16) ? 5'd16 : 5'(e);
            tests_run += 2;
            if (o_Fifo_Count !== want) begin tests_failed++; $display("[TB] FAIL overflow_count edge %0d got %0d expected %0d", e, o_Fifo_Count, want); end
            if (o_Tx_Ready !== (want != 5'd16)) begin tests_failed++; $display("[TB] FAIL overflow_ready edge %0d got %b expected %b", e, o_Tx_Ready, (want != 5'd16)); end
        end
        i_Tx_DV = 1'b0;
        while ((o_Tx_Active !== 1'b0 || o_Fifo_Count !== 5'd0) && guard < 1500) begin
            @(negedge i_Clock);
            guard++;
        end
        repeat (3) @(negedge i_Clock);
        tests_run += 2;
        if (guard >= 1500) begin tests_failed++; $display("[TB] FAIL overflow_drain got timeout expected idle"); end
        if (dec_q.size() != base + 17) begin
            tests_failed++; $display("[TB] FAIL overflow_frames got %0d expected 17", dec_q.size() - base);
        end else begin
            for (int i = 0; i < 17; i++) begin
                tests_run++;
                if (dec_q[base+i] !== 8'(i)) begin tests_failed++; $display("[TB] FAIL overflow_byte %0d got %h expected %h", i, dec_q[base+i], 8'(i)); end
            end
        end
    endtask

    task automatic test_push_pop();
        int base = dec_q.size();
        int guard = 0;
        @(negedge i_Clock);
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'h5A;
        @(negedge i_Clock);
        tests_run++;
        if (o_Fifo_Count !== 5'd1) begin tests_failed++; $display("[TB] FAIL pushpop_first got %0d expected 1", o_Fifo_Count); end
        i_Tx_Byte = 8'hC3;
        @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        tests_run++;
        if (o_Fifo_Count !== 5'd1) begin tests_failed++; $display("[TB] FAIL pushpop_same_edge got %0d expected 1", o_Fifo_Count); end
        while ((o_Tx_Active !== 1'b0 || o_Fifo_Count !== 5'd0) && guard < 500) begin
            @(negedge i_Clock);
            guard++;
        end
        repeat (3) @(negedge i_Clock);
        tests_run += 2;
        if (guard >= 500) begin tests_failed++; $display("[TB] FAIL pushpop_drain got timeout expected idle"); end
        if (dec_q.size() != base + 2) begin
            tests_failed++; $display("[TB] FAIL pushpop_frames got %0d expected 2", dec_q.size() - base);
        end else begin
            tests_run += 2;
            if (dec_q[base] !== 8'h5A) begin tests_failed++; $display("[TB] FAIL pushpop_order0 got %h expected 5a", dec_q[base]); end
            if (dec_q[base+1] !== 8'hC3) begin tests_failed++; $display("[TB] FAIL pushpop_order1 got %h expected c3", dec_q[base+1]); end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] first = 8'h11;
        int base = dec_q.size();
        int dones = 0;
        int lows = 0;
        @(negedge i_Clock);
        for (int i = 0; i < 5; i++) begin
            i_Tx_DV   = 1'b1;
            i_Tx_Byte = 8'(8'h11 * (i + 1));
            @(negedge i_Clock);
        end
        i_Tx_DV = 1'b0;
        repeat (14) @(negedge i_Clock);
        tests_run++;
        if (o_Tx_Serial !== first[3]) begin tests_failed++; $display("[TB] FAIL midreset_bit3 got %b expected %b", o_Tx_Serial, first[3]); end
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        tests_run += 4;
        if (o_Tx_Serial !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_line got %b expected 1", o_Tx_Serial); end
        if (o_Fifo_Count !== 5'd0) begin tests_failed++; $display("[TB] FAIL midreset_count got %0d expected 0", o_Fifo_Count); end
        if (o_Tx_Active !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_active got %b expected 0", o_Tx_Active); end
        if (o_Tx_Ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_ready got %b expected 1", o_Tx_Ready); end
        for (int c = 0; c < 100; c++) begin
            @(negedge i_Clock);
            if (o_Tx_Done === 1'b1) dones++;
            if (o_Tx_Serial !== 1'b1) lows++;
        end
        tests_run += 2;
        if (dones != 0) begin tests_failed++; $display("[TB] FAIL midreset_no_done got %0d pulses expected 0", dones); end
        if (lows != 0) begin tests_failed++; $display("[TB] FAIL midreset_line_idle got %0d low cycles expected 0", lows); end
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'h3C;
        @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge i_Clock);
            if (o_Tx_Done === 1'b1) dones++;
        end
        tests_run += 2;
        if (dones != 1) begin tests_failed++; $display("[TB] FAIL midreset_after_done got %0d expected 1", dones); end
        if (dec_q.size() != base + 1) begin
            tests_failed++; $display("[TB] FAIL midreset_after_frames got %0d expected 1", dec_q.size() - base);
        end else begin
            tests_run++;
            if (dec_q[base] !== 8'h3C) begin tests_failed++; $display("[TB] FAIL midreset_after_byte got %h expected 3c", dec_q[base]); end
        end
    endtask

    task automatic test_random();
        int dec_base = dec_q.size();
        int log_base = m_done_log.size();
        int err_base = dec_frame_err;
        int written_ready = 0;
        int gap;
        int quiet = 0;
        for (int n = 0; n < 1000 + 2000; n++) begin
            if (n < 1000) begin
                gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 70));
            end else begin
                gap = 0;
            end
            for (int c = 0; c <= gap; c++) begin
                @(negedge i_Clock);
                tests_run += 5;
                if (o_Tx_Serial !== exp_serial) begin tests_failed++; $display("[TB] FAIL rand_serial t=%0t got %b expected %b", $time, o_Tx_Serial, exp_serial); end
                if (o_Tx_Active !== exp_active) begin tests_failed++; $display("[TB] FAIL rand_active t=%0t got %b expected %b", $time, o_Tx_Active, exp_active); end
                if (o_Tx_Done !== exp_done) begin tests_failed++; $display("[TB] FAIL rand_done t=%0t got %b expected %b", $time, o_Tx_Done, exp_done); end
                if (o_Fifo_Count !== exp_count) begin tests_failed++; $display("[TB] FAIL rand_count t=%0t got %0d expected %0d", $time, o_Fifo_Count, exp_count); end
                if (o_Tx_Ready !== exp_ready) begin tests_failed++; $display("[TB] FAIL rand_ready t=%0t got %b expected %b", $time, o_Tx_Ready, exp_ready); end
                i_Tx_DV   = (n < 1000) && (c == gap);
                i_Tx_Byte = 8'($urandom);
                if (i_Tx_DV && o_Tx_Ready === 1'b1) written_ready++;
            end
            if (n >= 1000) begin
                if (m_fifo.size() == 0 && m_line_pos < 0 && m_busy == 0 && !m_done_next && !exp_done) quiet++;
                if (quiet >= 4) break;
            end
        end
        i_Tx_DV = 1'b0;
        tests_run += 4;
        if (quiet < 4) begin tests_failed++; $display("[TB] FAIL rand_drain got timeout expected idle"); end
        if (dec_frame_err != err_base) begin tests_failed++; $display("[TB] FAIL rand_framing got %0d errors expected 0", dec_frame_err - err_base); end
        if (m_done_log.size() - log_base != written_ready) begin tests_failed++; $display("[TB] FAIL rand_no_drop got %0d frames expected %0d", m_done_log.size() - log_base, written_ready); end
        if (dec_q.size() - dec_base != m_done_log.size() - log_base) begin
            tests_failed++; $display("[TB] FAIL rand_frames got %0d expected %0d", dec_q.size() - dec_base, m_done_log.size() - log_base);
        end else begin
            for (int i = 0; i < dec_q.size() - dec_base; i++) begin
                tests_run++;
                if (dec_q[dec_base+i] !== m_done_log[log_base+i]) begin tests_failed++; $display("[TB] FAIL rand_byte %0d got %h expected %h", i, dec_q[dec_base+i], m_done_log[log_base+i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per serial bit (115200 bps at 50 MHz); legal range 4..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving transmit FIFO entries; legal values are powers of two from 2 to 256.
REQ-003 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_Tx_DV, input, 1 bit: write strobe; pushes i_Tx_Byte when o_Tx_Ready=1.
REQ-006 The block SHALL have port i_Tx_Byte, input, 8 bits: data byte to transmit.
REQ-007 The block SHALL have port o_Tx_Ready, output, 1 bit: FIFO not full.
REQ-008 The block SHALL have port o_Tx_Serial, output, 1 bit: UART line, idle high.
REQ-009 The block SHALL have port o_Tx_Active, output, 1 bit: high while a frame is being shifted (START, DATA or STOP state).
REQ-010 The block SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse per completed frame.
REQ-011 The block SHALL have port o_Fifo_Count, output, clog2(FIFO_DEPTH)+1 bits: occupied FIFO entries, 0..FIFO_DEPTH.

Function
REQ-012 The frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit is held exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP: IDLE->START when the FIFO is non-empty (pop the head into the shift register); START->DATA after CLKS_PER_BIT cycles; DATA->STOP after the 8th bit; STOP->START if the FIFO is non-empty at the stop bit's last cycle, else STOP->IDLE.
REQ-014 A write SHALL be accepted on an edge where i_Tx_DV=1 and o_Tx_Ready=1; o_Fifo_Count increments on that edge.
REQ-015 When i_Tx_DV=1 and the FIFO is full, the write SHALL be dropped, with count, pointers and contents unchanged, even if a pop occurs on the same edge.
REQ-016 On an edge with both an accepted write and a pop, o_Fifo_Count SHALL remain unchanged and data order SHALL be preserved.
REQ-017 Latency: with IDLE and the FIFO empty, a byte accepted on edge k SHALL drive o_Tx_Serial low from edge k+2.
REQ-018 Back-to-back frames SHALL have zero idle gap: the next start bit begins on the cycle immediately after the previous stop bit's last cycle.
REQ-019 o_Tx_Done SHALL be high for exactly the one cycle following the stop bit's last cycle, once per frame.
REQ-020 o_Tx_Serial, o_Tx_Active and o_Tx_Done SHALL be registered outputs; o_Tx_Ready SHALL equal (o_Fifo_Count != FIFO_DEPTH).
REQ-021 The bit counter SHALL count 0..CLKS_PER_BIT-1 and the bit index 0..7, with no wrap into the next bit.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 In IDLE, o_Tx_Serial SHALL be 1 and o_Tx_Active SHALL be 0.

Reset
REQ-024 While i_Reset=1 on an edge, the block SHALL set state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, and clear the FIFO pointers and counters.
REQ-025 A reset during a frame SHALL abort it immediately: the line is high after the reset edge, no o_Tx_Done pulse follows, and queued bytes are discarded.
REQ-026 A write coincident with reset SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=16)
REQ-027 Single byte: write 0xA5 at edge 0 -> line low for edges 2..5, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, high stop for edges 38..41, o_Tx_Done pulse after edge 41, o_Tx_Active high for edges 2..41.
REQ-028 Back-to-back: write 0x01, 0x02, 0x03 on consecutive edges -> three frames of 40 cycles each with no gap, three o_Tx_Done pulses 40 cycles apart, count returns to 0.
REQ-029 Overflow: hold the FSM busy, write 18 bytes 0x00..0x11 -> count saturates at 16 (one byte already popped), o_Tx_Ready=0, the extra byte is dropped, and the serial output sequence is 0x00..0x10.
REQ-030 Simultaneous push/pop: write on the same edge as the IDLE->START pop with count=1 -> count stays 1 and frames stay in order.
REQ-031 Mid-frame reset: assert i_Reset during data bit 3 with 5 bytes queued -> line high on the next edge, count=0, no o_Tx_Done pulse; the next write transmits normally.
REQ-032 Random: 1000 random bytes at random write rates, checked against a serial-decoding model -> exact byte sequence, no drops while o_Tx_Ready=1.
